// File: rtl/cntr_bank_reader_pkg.sv
// Shared definitions for the counter-bank reader: default bank geometry and FSM encoding.
package cntr_bank_reader_pkg;

  localparam int NUM_CNTR_DEF = 8;
  localparam int CNTR_W_DEF   = 4;
  localparam int IDX_W_DEF    = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/cntr_bank_reader_lane_step_chk.sv
// Single-lane step checker: flags a lane whose value is not prev +/- 1 (mod 2^CNTR_W).
module lane_step_chk #(
  parameter int CNTR_W = 4
) (
  input  logic [CNTR_W-1:0] prev,
  input  logic [CNTR_W-1:0] cur,
  input  logic              sense_q,
  output logic              mis
);

  // Natural wrap of CNTR_W-bit arithmetic makes F->0 (up) and 0->F (down) legal.
  function automatic logic [CNTR_W-1:0] step_val(input logic [CNTR_W-1:0] v, input logic up);
    return up ? v + CNTR_W'(1) : v - CNTR_W'(1);
  endfunction

  assign mis = (cur != step_val(prev, sense_q));

endmodule

// File: rtl/cntr_bank_reader.sv
// Consumer of the packed counter bank: per-lane step checking with sticky error flags,
// plus on-demand snapshot streamed one lane per beat over valid/ready.
module cntr_bank_reader
  import cntr_bank_reader_pkg::*;
#(
  parameter int NUM_CNTR = NUM_CNTR_DEF,
  parameter int CNTR_W   = CNTR_W_DEF,
  parameter int IDX_W    = IDX_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sense,
  input  logic [NUM_CNTR*CNTR_W-1:0]   bank_in,
  input  logic                         snap_req,
  output logic                         busy,
  output logic                         nib_valid,
  input  logic                         nib_ready,
  output logic [CNTR_W-1:0]            nib_data,
  output logic [IDX_W-1:0]             nib_idx,
  output logic                         nib_last,
  output logic                         err_flag,
  output logic [NUM_CNTR-1:0]          err_lane,
  input  logic                         err_clr
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNTR - 1);

  logic [NUM_CNTR*CNTR_W-1:0] prev_bank_p0;
  logic                       sense_p0;
  logic                       vld_p0;
  logic [NUM_CNTR-1:0]        mis;
  logic [NUM_CNTR-1:0]        new_err;

  state_t                     state;
  logic [NUM_CNTR*CNTR_W-1:0] snap;
  logic [IDX_W-1:0]           idx;
  logic [CNTR_W-1:0]          snap_lane [NUM_CNTR];

  // Stage p0: previous bank and direction, compared against the live bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_bank_p0 <= '0;
      sense_p0     <= 1'b0;
      vld_p0       <= 1'b0;
    end else begin
      prev_bank_p0 <= bank_in;
      sense_p0     <= sense;
      vld_p0       <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_CNTR; gi++) begin : g_lane
    lane_step_chk #(.CNTR_W(CNTR_W)) u_chk (
      .prev    (prev_bank_p0[gi*CNTR_W +: CNTR_W]),
      .cur     (bank_in[gi*CNTR_W +: CNTR_W]),
      .sense_q (sense_p0),
      .mis     (mis[gi])
    );
    assign snap_lane[gi] = snap[gi*CNTR_W +: CNTR_W];
  end

  assign new_err = vld_p0 ? mis : '0;

  // Stage p1: sticky flags; a fresh mis-step survives a concurrent clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_lane <= '0;
      err_flag <= 1'b0;
    end else begin
      err_lane <= (err_clr ? '0 : err_lane) | new_err;
      err_flag <= (err_clr ? 1'b0 : err_flag) | (|new_err);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      snap      <= '0;
      idx       <= '0;
      busy      <= 1'b0;
      nib_valid <= 1'b0;
      nib_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snap_req) begin
            snap      <= bank_in;
            idx       <= '0;
            state     <= SEND;
            busy      <= 1'b1;
            nib_valid <= 1'b1;
            nib_last  <= (NUM_CNTR == 1);
          end
        end
        SEND: begin
          if (nib_ready) begin
            if (nib_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              nib_valid <= 1'b0;
              nib_last  <= 1'b0;
            end else begin
              idx      <= idx + IDX_W'(1);
              nib_last <= ((idx + IDX_W'(1)) == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

  assign nib_data = snap_lane[idx];
  assign nib_idx  = idx;

endmodule

// File: tb/tb_cntr_bank_reader.sv
// Directed bench for cntr_bank_reader: step checking, snapshot streaming, stalls, reset abort.
module tb_cntr_bank_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        sense;
  logic [31:0] bank_in;
  logic        snap_req;
  logic        busy;
  logic        nib_valid;
  logic        nib_ready;
  logic [3:0]  nib_data;
  logic [2:0]  nib_idx;
  logic        nib_last;
  logic        err_flag;
  logic [7:0]  err_lane;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cntr_bank_reader #(.NUM_CNTR(8), .CNTR_W(4), .IDX_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .sense     (sense),
    .bank_in   (bank_in),
    .snap_req  (snap_req),
    .busy      (busy),
    .nib_valid (nib_valid),
    .nib_ready (nib_ready),
    .nib_data  (nib_data),
    .nib_idx   (nib_idx),
    .nib_last  (nib_last),
    .err_flag  (err_flag),
    .err_lane  (err_lane),
    .err_clr   (err_clr)
  );

  function automatic logic [31:0] fill(input logic [3:0] v);
    return {8{v}};
  endfunction

  function automatic logic [31:0] set_lane(input logic [31:0] b, input int i, input logic [3:0] v);
    logic [31:0] r;
    r = b;
    r[i*4 +: 4] = v;
    return r;
  endfunction

  task automatic do_reset(input logic dir);
    @(negedge clk);
    reset = 1'b1; sense = dir; bank_in = fill(4'h0); snap_req = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (nib_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", nib_valid); end
    checks++; if (nib_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", nib_data); end
    checks++; if (nib_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", nib_idx); end
    checks++; if (nib_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", nib_last); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_err_flag: got %b want 0", err_flag); end
    checks++; if (err_lane !== 8'h00) begin errors++; $display("FAIL reset_err_lane: got %h want 00", err_lane); end
  endtask

  task automatic test_count_up();
    sense = 1'b1; bank_in = fill(4'h0);
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if (err_flag !== 1'b0) begin errors++; $display("FAIL up_err_flag k=%0d: got %b want 0", k, err_flag); end
      bank_in = fill(4'(k));
    end
    @(negedge clk);
    checks++; if (err_lane !== 8'h00) begin errors++; $display("FAIL up_err_lane: got %h want 00", err_lane); end
  endtask

  task automatic test_count_down();
    do_reset(1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (err_flag !== 1'b0) begin errors++; $display("FAIL down_err_flag k=%0d: got %b want 0", k, err_flag); end
      bank_in = fill(4'(-k));
    end
    @(negedge clk);
    bank_in = set_lane(fill(4'(-21)), 5, 4'(-20));
    @(negedge clk);
    checks++; if (err_lane !== 8'h20) begin errors++; $display("FAIL down_hold_lane: got %h want 20", err_lane); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL down_hold_flag: got %b want 1", err_flag); end
    bank_in = set_lane(fill(4'(-22)), 5, 4'(-21));
    @(negedge clk);
    checks++; if (err_lane !== 8'h20) begin errors++; $display("FAIL down_sticky: got %h want 20", err_lane); end
    bank_in = set_lane(fill(4'(-23)), 5, 4'(-22));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_lane !== 8'h00) begin errors++; $display("FAIL down_clr_lane: got %h want 00", err_lane); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL down_clr_flag: got %b want 0", err_flag); end
  endtask

  task automatic test_snapshot();
    @(negedge clk);
    bank_in = 32'h76543210; nib_ready = 1'b1; snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (nib_valid !== 1'b1 || busy !== 1'b1 || nib_idx !== 3'(i) || nib_data !== 4'(i) || nib_last !== (i == 7)) begin
        errors++;
        $display("FAIL snap_beat%0d: valid=%b busy=%b idx=%0d data=%h last=%b want 1 1 %0d %h %b",
                 i, nib_valid, busy, nib_idx, nib_data, nib_last, i, 4'(i), (i == 7));
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || nib_valid !== 1'b0) begin
      errors++; $display("FAIL snap_idle: busy=%b valid=%b want 0 0", busy, nib_valid);
    end
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    int e;
    int cyc;
    pat = 4'b1001;
    e = 0; cyc = 0;
    @(negedge clk);
    bank_in = 32'h76543210; nib_ready = 1'b0; snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    while (e < 8 && cyc < 64) begin
      checks++;
      if (nib_valid !== 1'b1 || nib_idx !== 3'(e) || nib_data !== 4'(e) || nib_last !== (e == 7)) begin
        errors++;
        $display("FAIL stall_beat cyc=%0d: valid=%b idx=%0d data=%h last=%b want 1 %0d %h %b",
                 cyc, nib_valid, nib_idx, nib_data, nib_last, e, 4'(e), (e == 7));
      end
      nib_ready = pat[cyc % 4];
      bank_in = $urandom;
      @(negedge clk);
      if (nib_ready) e++;
      cyc++;
    end
    checks++; if (e != 8) begin errors++; $display("FAIL stall_timeout: beats=%0d want 8", e); end
    checks++;
    if (busy !== 1'b0 || nib_valid !== 1'b0) begin
      errors++; $display("FAIL stall_idle: busy=%b valid=%b want 0 0", busy, nib_valid);
    end
    nib_ready = 1'b1;
  endtask

  task automatic test_req_during_send();
    int beats;
    beats = 0;
    @(negedge clk);
    bank_in = 32'h76543210; nib_ready = 1'b1; snap_req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      snap_req = (i == 2 || i == 5 || i == 7);
      if (nib_valid === 1'b1) beats++;
      checks++;
      if (nib_idx !== 3'(i) || nib_data !== 4'(i)) begin
        errors++; $display("FAIL req_send_beat%0d: idx=%0d data=%h want %0d %h", i, nib_idx, nib_data, i, 4'(i));
      end
      @(negedge clk);
    end
    snap_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (nib_valid === 1'b1) beats++;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL req_send_idle%0d: busy=%b want 0", i, busy); end
      @(negedge clk);
    end
    checks++; if (beats != 8) begin errors++; $display("FAIL req_send_count: beats=%0d want 8", beats); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    cyc = 0;
    @(negedge clk);
    bank_in = 32'h76543210; nib_ready = 1'b1; snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    while (nib_idx !== 3'd3 && cyc < 16) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (nib_idx !== 3'd3 || nib_valid !== 1'b1) begin errors++; $display("FAIL mid_reach3: idx=%0d valid=%b want 3 1", nib_idx, nib_valid); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL mid_pre_err: got %b want 1", err_flag); end
    reset = 1'b1;
    #1;
    checks++;
    if (nib_valid !== 1'b0 || busy !== 1'b0 || err_flag !== 1'b0 || err_lane !== 8'h00) begin
      errors++;
      $display("FAIL mid_abort: valid=%b busy=%b err_flag=%b err_lane=%h want 0 0 0 00", nib_valid, busy, err_flag, err_lane);
    end
    @(negedge clk);
    reset = 1'b0;
    bank_in = 32'hFEDCBA98; snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (nib_valid !== 1'b1 || nib_idx !== 3'(i) || nib_data !== 4'(8 + i)) begin
        errors++;
        $display("FAIL mid_restart%0d: valid=%b idx=%0d data=%h want 1 %0d %h", i, nib_valid, nib_idx, nib_data, i, 4'(8 + i));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_err_clr();
    do_reset(1'b1);
    bank_in = fill(4'h0);
    @(negedge clk);
    bank_in = fill(4'h1);
    @(negedge clk);
    bank_in = fill(4'h2);
    @(negedge clk);
    checks++; if (err_lane !== 8'h00) begin errors++; $display("FAIL clr_pre: got %h want 00", err_lane); end
    bank_in = set_lane(fill(4'h3), 0, 4'h5);
    @(negedge clk);
    checks++; if (err_lane !== 8'h01) begin errors++; $display("FAIL clr_lane0: got %h want 01", err_lane); end
    bank_in = set_lane(set_lane(fill(4'h4), 0, 4'h6), 2, 4'h9);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_lane !== 8'h04) begin errors++; $display("FAIL clr_concurrent_lane: got %h want 04", err_lane); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL clr_concurrent_flag: got %b want 1", err_flag); end
    bank_in = set_lane(set_lane(fill(4'h5), 0, 4'h7), 2, 4'hA);
    @(negedge clk);
    checks++; if (err_lane !== 8'h04) begin errors++; $display("FAIL clr_sticky: got %h want 04", err_lane); end
  endtask

  initial begin
    reset = 1'b1; sense = 1'b1; bank_in = 32'h0; snap_req = 1'b0;
    nib_ready = 1'b1; err_clr = 1'b0;
    test_reset();
    test_count_up();
    test_count_down();
    test_snapshot();
    test_stall();
    test_req_during_send();
    test_reset_mid();
    test_err_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
